// File: rtl/magnitude_accumulator_if.sv
// Handshake bundle for magnitude_accumulator: sample input side and block-result output side.
// out_peak exists only when MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN is defined.
interface magnitude_accumulator_if #(
  parameter int SUM_W = 9
);
  logic             in_valid;
  logic [5:0]       in_mag;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [4:0]       out_len;
  logic             out_sat;
`ifdef MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN
  logic [5:0]       out_peak;

  modport master (
    output in_valid, in_mag, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_len, out_sat, out_peak
  );

  modport slave (
    input  in_valid, in_mag, flush, out_ready,
    output in_ready, out_valid, out_sum, out_len, out_sat, out_peak
  );
`else
  modport master (
    output in_valid, in_mag, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_len, out_sat
  );

  modport slave (
    input  in_valid, in_mag, flush, out_ready,
    output in_ready, out_valid, out_sum, out_len, out_sat
  );
`endif
endinterface

// File: rtl/magnitude_accumulator.sv
// Saturating block accumulator of magnitude samples; result latency 1 cycle after the closing accept, held until out_ready.
// Optional peak tracking via MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN; in_ready drops while a result is held.
module magnitude_accumulator #(
  parameter int BLOCK_LEN = 8,
  parameter int SUM_W     = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  magnitude_accumulator_if.slave bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [SUM_W:0] SUM_MAX = {1'b0, {SUM_W{1'b1}}};
  localparam logic [4:0]     LEN_END = 5'(BLOCK_LEN);

  state_t           state, state_nxt;
  logic [SUM_W-1:0] sum, sum_nxt;
  logic [4:0]       count, count_nxt;
  logic             sat, sat_nxt;

  logic             ready_int;
  logic             valid_int;
  logic             accept;
  logic [SUM_W:0]   sum_ext;
  logic             over;
  logic [4:0]       count_inc;

`ifdef MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN
  logic [5:0]       peak, peak_nxt;
`endif

  assign ready_int = (state == ACCUM) && !rst;
  assign valid_int = (state == HOLD) && !rst;
  assign accept    = bus.in_valid && ready_int;
  // One guard bit catches the carry; in_mag is added unchanged, even above 32.
  assign sum_ext   = {1'b0, sum} + {{(SUM_W-5){1'b0}}, bus.in_mag};
  assign over      = sum_ext > SUM_MAX;
  assign count_inc = count + 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      sum   <= '0;
      count <= '0;
      sat   <= 1'b0;
`ifdef MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN
      peak  <= '0;
`endif
    end else begin
      state <= state_nxt;
      sum   <= sum_nxt;
      count <= count_nxt;
      sat   <= sat_nxt;
`ifdef MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN
      peak  <= peak_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    sum_nxt   = sum;
    count_nxt = count;
    sat_nxt   = sat;
`ifdef MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN
    peak_nxt  = peak;
`endif
    case (state)
      ACCUM: begin
        if (accept) begin
          sum_nxt   = over ? SUM_MAX[SUM_W-1:0] : sum_ext[SUM_W-1:0];
          sat_nxt   = sat | over;
          count_nxt = count_inc;
`ifdef MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN
          if (bus.in_mag > peak) peak_nxt = bus.in_mag;
`endif
        end
        // A flush closes the block only if it will hold at least one sample.
        if ((accept && (count_inc == LEN_END)) ||
            (bus.flush && (accept || (count != 5'd0)))) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_nxt = ACCUM;
          sum_nxt   = '0;
          count_nxt = '0;
          sat_nxt   = 1'b0;
`ifdef MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN
          peak_nxt  = '0;
`endif
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  assign bus.in_ready  = ready_int;
  assign bus.out_valid = valid_int;
  assign bus.out_sum   = valid_int ? sum   : '0;
  assign bus.out_len   = valid_int ? count : '0;
  assign bus.out_sat   = valid_int ? sat   : 1'b0;
`ifdef MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN
  assign bus.out_peak  = valid_int ? peak  : '0;
`endif

endmodule

// File: tb/tb_magnitude_accumulator.sv
// Scoreboard bench for magnitude_accumulator (BLOCK_LEN=8, SUM_W=7): reference model pushes expected blocks, monitor compares.
module tb_magnitude_accumulator;

  localparam int BL    = 8;
  localparam int SUM_W = 7;
  localparam int MAX   = (1 << SUM_W) - 1;

  typedef struct {
    int sum;
    int len;
    int sat;
    int peak;
  } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  magnitude_accumulator_if #(.SUM_W(SUM_W)) bus ();

  magnitude_accumulator #(.BLOCK_LEN(BL), .SUM_W(SUM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  blk_t sb[$];

  int m_hold = 0, m_sum = 0, m_cnt = 0, m_sat = 0, m_peak = 0;
  int n_ret = 0, vld_cycles = 0;
  int obs_sum = 0, obs_len = 0, obs_sat = 0, obs_peak = 0;
  int last_sum = -1, last_len = -1, last_sat = -1, last_peak = -1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model on the rising edge, check outputs on the falling edge.
  task automatic cycle(input logic r, input logic v, input int mag, input logic f, input logic o);
    blk_t b;
    int   t;
    rst           = r;
    bus.in_valid  = v;
    bus.in_mag    = 6'(mag);
    bus.flush     = f;
    bus.out_ready = o;
    @(posedge clk);
    if (r) begin
      m_hold = 0; m_sum = 0; m_cnt = 0; m_sat = 0; m_peak = 0;
      sb.delete();
    end else if (m_hold != 0) begin
      if (o) begin
        m_hold = 0; m_sum = 0; m_cnt = 0; m_sat = 0; m_peak = 0;
        if (sb.size() > 0) void'(sb.pop_front());
        last_sum = obs_sum; last_len = obs_len; last_sat = obs_sat; last_peak = obs_peak;
        n_ret++;
      end
    end else begin
      if (v) begin
        t = m_sum + (mag & 63);
        if (t > MAX) begin
          m_sum = MAX;
          m_sat = 1;
        end else begin
          m_sum = t;
        end
        m_cnt++;
        if ((mag & 63) > m_peak) m_peak = mag & 63;
      end
      if ((v && m_cnt == BL) || (f && m_cnt >= 1)) begin
        m_hold = 1;
        b.sum = m_sum; b.len = m_cnt; b.sat = m_sat; b.peak = m_peak;
        sb.push_back(b);
      end
    end
    @(negedge clk);
    if (bus.out_valid) vld_cycles++;
    if (rst) begin
      chk("rst_in_ready",  int'(bus.in_ready),  0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_sum",   int'(bus.out_sum),   0);
      chk("rst_out_len",   int'(bus.out_len),   0);
      chk("rst_out_sat",   int'(bus.out_sat),   0);
    end else if (m_hold != 0) begin
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_in_ready",  int'(bus.in_ready),  0);
      chk("sb_depth",       sb.size(),           1);
      if (sb.size() > 0) begin
        chk("blk_sum", int'(bus.out_sum), sb[0].sum);
        chk("blk_len", int'(bus.out_len), sb[0].len);
        chk("blk_sat", int'(bus.out_sat), sb[0].sat);
`ifdef MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN
        chk("blk_peak", int'(bus.out_peak), sb[0].peak);
`endif
      end
      obs_sum = int'(bus.out_sum);
      obs_len = int'(bus.out_len);
      obs_sat = int'(bus.out_sat);
`ifdef MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN
      obs_peak = int'(bus.out_peak);
`endif
    end else begin
      chk("acc_out_valid", int'(bus.out_valid), 0);
      chk("acc_in_ready",  int'(bus.in_ready),  1);
      chk("acc_out_sum",   int'(bus.out_sum),   0);
      chk("acc_out_len",   int'(bus.out_len),   0);
      chk("acc_out_sat",   int'(bus.out_sat),   0);
    end
  endtask

  task automatic idle(input logic o);
    cycle(1'b0, 1'b0, 0, 1'b0, o);
  endtask

  initial begin
    int vc;
    int start;
    int budget;
    bus.in_valid  = 1'b0;
    bus.in_mag    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    // Reset with every other input active
    cycle(1'b1, 1'b1, 9, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 9, 1'b1, 1'b1);

    // 1..8 back to back, result visible for exactly one cycle
    vc = vld_cycles;
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, i, 1'b0, 1'b1);
    idle(1'b1);
    chk("t1_sum", last_sum, 36);
    chk("t1_len", last_len, 8);
    chk("t1_sat", last_sat, 0);
    chk("t1_vld_cycles", vld_cycles - vc, 1);
`ifdef MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN
    chk("t1_peak", last_peak, 8);
`endif

    // Saturation at 2^SUM_W-1
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 32, 1'b0, 1'b1);
    idle(1'b1);
    chk("t2_sum", last_sum, 127);
    chk("t2_sat", last_sat, 1);
    chk("t2_len", last_len, 8);

    // Flush with a same-cycle accept, then flush on an empty block
    cycle(1'b0, 1'b1, 5, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 7, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 3, 1'b1, 1'b1);
    idle(1'b1);
    chk("t3_sum", last_sum, 15);
    chk("t3_len", last_len, 3);
    vc = vld_cycles;
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
    idle(1'b1);
    chk("t3_empty_flush_vld", vld_cycles - vc, 0);

    // Back-pressure: held result, ignored samples, no same-cycle bypass on release
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 20, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 9, 1'b0, 1'b1);
    chk("t4_sum", last_sum, 32);
    chk("t4_len", last_len, 8);
    cycle(1'b0, 1'b1, 9, 1'b1, 1'b1);
    idle(1'b1);
    chk("t4_next_sum", last_sum, 9);
    chk("t4_next_len", last_len, 1);

    // Reset mid-block discards the partial sum
    vc = vld_cycles;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 10, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 10, 1'b0, 1'b1);
    idle(1'b1);
    chk("t5_post_rst_sum", int'(bus.out_sum), 0);
    chk("t5_post_rst_len", int'(bus.out_len), 0);
    chk("t5_post_rst_vld", int'(bus.out_valid), 0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1, 1'b0, 1'b1);
    idle(1'b1);
    chk("t5_sum", last_sum, 8);
    chk("t5_len", last_len, 8);
    chk("t5_vld_cycles", vld_cycles - vc, 1);

    // Reset while a result is pending: it is never emitted
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 2, 1'b0, 1'b0);
    start = n_ret;
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b1);
    idle(1'b1);
    chk("t5b_discard", n_ret - start, 0);

    // Randomised gaps over 100 blocks
    start  = n_ret;
    budget = 0;
    while ((n_ret - start) < 100 && budget < 20000) begin
      int  mag;
      int  sel;
      sel = int'($urandom_range(0, 15));
      if (sel == 0)      mag = int'($urandom_range(33, 63));
      else if (sel < 3)  mag = 32;
      else               mag = int'($urandom_range(0, 12));
      cycle(1'b0, $urandom_range(0, 3) != 0, mag,
            $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
      budget++;
    end
    chk("rand_blocks", n_ret - start, 100);
    idle(1'b1);
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/magnitude_accumulator.md
MAGNITUDE_ACCUMULATOR -- requirements
Module: magnitude_accumulator

Interface
REQ-001 Parameter BLOCK_LEN, default 8, is the number of samples per block; legal range is 2..16.
REQ-002 Parameter SUM_W, default 9, is the width of the block sum in bits; legal range is 7..12.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  is a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  indicates that upstream is presenting a magnitude sample.
REQ-006 in_mag  input  6  is an unsigned magnitude from the absolute-value stage; legal range is 0..32, and 6'b100000 means 32.
REQ-007 in_ready  output  1  indicates the block accepts in_mag this cycle.
REQ-008 flush  input  1  requests early closure of a partial block.
REQ-009 out_valid  output  1  indicates a block result is presented.
REQ-010 out_ready  input  1  indicates downstream consumes the result.
REQ-011 out_sum  output  SUM_W  is the sum of the accepted magnitudes in the block.
REQ-012 out_len  output  5  is the number of samples in the reported block (1..BLOCK_LEN).
REQ-013 out_sat  output  1  indicates the sum saturated during the block.

Function
REQ-014 The FSM SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 A sample SHALL be accepted only on a cycle where in_valid=1 and in_ready=1; each accept adds in_mag to the sum register and increments the count.
REQ-016 The sum SHALL saturate at 2^SUM_W-1; the first cycle whose addition would exceed that value sets a sticky sat flag for the block.
REQ-017 ACCUM->HOLD SHALL occur on the edge where the accepted sample brings the count to BLOCK_LEN; out_valid asserts the next cycle (latency 1 from the final accept).
REQ-018 ACCUM->HOLD SHALL also occur on flush=1 if the count after this cycle's possible accept is at least 1; a sample accepted on the same cycle as flush is included in the block.
REQ-019 flush=1 with count 0 and no accept SHALL be ignored; flush in HOLD SHALL be ignored.
REQ-020 In HOLD, out_sum, out_len, and out_sat SHALL stay stable until out_ready=1.
REQ-021 HOLD->ACCUM SHALL occur on the edge where out_ready=1; sum, count, and sat clear on that edge, and in_ready=1 the next cycle.
REQ-022 No sample SHALL be accepted in the cycle where out_ready retires a result, so there is no same-cycle bypass.
REQ-023 in_mag values above 32 SHALL be added unchanged; no range check is performed.

Reset
REQ-024 While rst=1, the FSM SHALL be in ACCUM with sum=0, count=0, and sat=0.
REQ-025 While rst=1, the outputs SHALL be in_ready=0, out_valid=0, out_sum=0, out_len=0, and out_sat=0.
REQ-026 rst SHALL dominate in_valid, flush, and out_ready in the same cycle.
REQ-027 rst asserted mid-block or in HOLD SHALL discard the partial or pending result without emitting it.

Configuration
REQ-028 With the macro MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN defined, a 6-bit output out_peak SHALL report the maximum in_mag accepted in the block.
REQ-029 With MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN defined, out_peak SHALL be held with out_sum, reset to 0, and cleared together with the sum.
REQ-030 Without MAGNITUDE_ACCUMULATOR_PEAK_HOLD_EN, the port out_peak and its register SHALL NOT exist, and all other behaviour is unchanged.

Verification
REQ-031 BLOCK_LEN=8: accept 1,2,...,8 back-to-back, with out_ready=1 -> out_valid for 1 cycle one edge after the 8th accept; out_sum=36, out_len=8, out_sat=0, and peak=8 when enabled.
REQ-032 BLOCK_LEN=8, SUM_W=7: eight samples of 32 -> out_sum=127, out_sat=1, out_len=8.
REQ-033 Accept 5,7, then flush=1 together with in_mag=3 accepted -> out_sum=15, out_len=3; flush alone at count 0 -> no out_valid.
REQ-034 Complete a block with out_ready=0 for 5 cycles -> out_valid and out_sum stay constant, in_ready=0, and no in_valid is accepted; a first sample presented after release is counted only in the next block.
REQ-035 Pulse rst after 4 accepts of 10 -> all outputs 0 the cycle after; the next 8 accepts of 1 give out_sum=8, out_len=8.
REQ-036 Randomised valid/ready gaps over 100 blocks -> out_sum matches a scoreboard sum of accepted samples, and no sample is lost or duplicated.
